blood_ctrl: RTL and testbench
=============================

BLOOD_CTRL -- requirements
Module: blood_ctrl

Interface
REQ-001 Parameter HP_MAX, default 61, maximum health points.
REQ-002 Parameter IFRAMES, default 30, invulnerability length in frames after a hit.
REQ-003 Parameter BAR_OFFSET, default 2, added to displayed health to form blood.
REQ-004 Clk  input  1  system clock; the block SHALL use one clock only, with all state updated on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 frame_clk  input  1  vertical-sync-rate frame strobe, asynchronous to Clk.
REQ-007 hit  input  1  one-Clk damage request pulse.
REQ-008 damage  input  7  damage amount, sampled only with hit.
REQ-009 heal  input  1  one-Clk heal request pulse.
REQ-010 heal_amt  input  7  heal amount, sampled only with heal.
REQ-011 revive  input  1  one-Clk revive pulse.
REQ-012 blood  output  7  bar fill column, range BAR_OFFSET..BAR_OFFSET+HP_MAX (2..63), consumed by the bar renderer.
REQ-013 is_dead  output  1  high while state is DEAD.
REQ-014 hurt_flash  output  1  sprite blink enable during invulnerability.

Function
REQ-015 frame_clk SHALL pass through a 2-flop synchronizer; its rising edge SHALL produce frame_tick, high for exactly one Clk.
REQ-016 The block SHALL hold target_hp (0..HP_MAX) and disp_hp (0..HP_MAX), both 6-bit unsigned, plus a state in {ALIVE, HURT, DEAD}.
REQ-017 ALIVE + hit: target_hp SHALL become max(0, target_hp - damage), computed at 8 bits with saturation and no wrap.
REQ-018 ALIVE + hit with a result of 0: next state SHALL be DEAD; otherwise next state SHALL be HURT with iframe_cnt = IFRAMES.
REQ-019 HURT or DEAD + hit: the hit SHALL be ignored.
REQ-020 ALIVE or HURT + heal: target_hp SHALL become min(HP_MAX, target_hp + heal_amt), computed at 8 bits with saturation.
REQ-021 heal in DEAD SHALL be ignored.
REQ-022 hit and heal in the same cycle in ALIVE: the hit SHALL be applied and the heal dropped.
REQ-023 hit and heal in the same cycle in HURT: the heal SHALL be applied.
REQ-024 HURT: iframe_cnt SHALL decrement on each frame_tick; a frame_tick with iframe_cnt==1 SHALL return the state to ALIVE on the next cycle.
REQ-025 DEAD + revive: target_hp SHALL be set to HP_MAX and the state SHALL become ALIVE; revive SHALL be ignored in every other state.
REQ-026 On frame_tick with disp_hp > target_hp: disp_hp SHALL decrement by 1 (drain animation).
REQ-027 On frame_tick with disp_hp < target_hp: disp_hp SHALL increase by min(2, target_hp - disp_hp).
REQ-028 disp_hp SHALL change only on frame_tick and SHALL never overshoot target_hp.
REQ-029 blood SHALL be registered as disp_hp + BAR_OFFSET, one Clk after disp_hp updates.
REQ-030 is_dead SHALL be registered and equal (state==DEAD); it SHALL assert the cycle after the fatal hit, independent of the drain progress.
REQ-031 hurt_flash SHALL equal (state==HURT) AND iframe_cnt[2], and SHALL be registered.

Reset
REQ-032 Reset SHALL set target_hp=HP_MAX, disp_hp=HP_MAX, blood=63, state=ALIVE, iframe_cnt=0, is_dead=0, hurt_flash=0, and clear the synchronizer flops.
REQ-033 Reset asserted mid-drain or in HURT/DEAD SHALL take priority over all inputs in that cycle.
REQ-034 No frame_tick SHALL be produced in the first cycle after reset is released.

Structure
REQ-035 A shared package blood_pkg SHALL hold HP_MAX, BAR_OFFSET, IFRAMES and the state enum hp_state_t (ALIVE, HURT, DEAD).
REQ-036 The block SHALL contain one sub-module, frame_tick_gen (synchronizer plus rising-edge detector), reusable by other frame-paced blocks.

Verification
REQ-037 Reset, then 3 frame ticks -> blood=63, is_dead=0, hurt_flash toggles never.
REQ-038 hit with damage=10 in ALIVE -> target_hp=51, state HURT; blood steps 63,62,...,53 over 10 frame ticks; a second hit during HURT leaves target_hp at 51.
REQ-039 hit with damage=100 -> is_dead=1 next cycle; blood drains 1 per frame to 2 and holds; a heal while dead has no effect.
REQ-040 After death, revive pulse -> state ALIVE, is_dead=0; blood rises by 2 per frame from 2 to 63, with final step +1 (62->63).
REQ-041 Same-cycle hit(5) and heal(20) at target_hp=61 in ALIVE -> target_hp=56; then heal_amt=20 in HURT -> target_hp=61 (saturated).
REQ-042 Assert Reset during HURT with disp_hp=40 -> next cycle blood=63, state ALIVE, hurt_flash=0.

Source files
------------

// File: rtl/blood_pkg.sv
// Shared constants, state encoding and saturating helpers for the health bar.
package blood_pkg;

    localparam int unsigned HP_MAX     = 61;
    localparam int unsigned IFRAMES    = 30;
    localparam int unsigned BAR_OFFSET = 2;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        HURT  = 2'd1,
        DEAD  = 2'd2
    } hp_state_t;

    // a - b, clamped at zero instead of wrapping
    function automatic logic [5:0] sat_sub(input logic [5:0] a, input logic [6:0] b);
        if (b > {1'b0, a})
            return '0;
        else
            return a - b[5:0];
    endfunction

    // a + b, clamped at lim; the sum is formed at 8 bits so it cannot wrap
    function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [6:0] b,
                                           input logic [5:0] lim);
        logic [7:0] s;
        s = {2'b00, a} + {1'b0, b};
        if (s > {2'b00, lim})
            return lim;
        else
            return s[5:0];
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the vsync-rate frame strobe into the Clk domain and turns each
// rising edge into a single-cycle frame_tick.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic sync0, sync1, sync_q;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            sync0  <= frame_clk;
            sync1  <= sync0;
            sync_q <= sync1;
        end
    end

    assign frame_tick = sync1 & ~sync_q;

endmodule

// File: rtl/blood_ctrl.sv
// Player health controller: tracks target health, animates the displayed
// health toward it once per frame, and drives the bar fill column.
module blood_ctrl #(
    parameter int unsigned HP_MAX     = blood_pkg::HP_MAX,
    parameter int unsigned IFRAMES    = blood_pkg::IFRAMES,
    parameter int unsigned BAR_OFFSET = blood_pkg::BAR_OFFSET
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       hit,
    input  logic [6:0] damage,
    input  logic       heal,
    input  logic [6:0] heal_amt,
    input  logic       revive,
    output logic [6:0] blood,
    output logic       is_dead,
    output logic       hurt_flash
);

    import blood_pkg::*;

    localparam logic [5:0] HP_FULL = 6'(HP_MAX);
    localparam logic [7:0] IF_LOAD = 8'(IFRAMES);
    localparam logic [6:0] OFS     = 7'(BAR_OFFSET);

    hp_state_t  state, state_n;
    logic [5:0] target_hp, target_n;
    logic [5:0] disp_hp, disp_n, disp_gap;
    logic [7:0] iframe_cnt, iframe_n;
    logic       frame_tick;

    frame_tick_gen u_tick (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    // Next health state: hits only land while ALIVE, heals outside DEAD,
    // revive only from DEAD; invulnerability counts down on frame ticks
    always_comb begin
        state_n  = state;
        target_n = target_hp;
        iframe_n = iframe_cnt;
        unique case (state)
            ALIVE: begin
                if (hit) begin
                    target_n = sat_sub(target_hp, damage);
                    if (target_n == '0) begin
                        state_n = DEAD;
                    end else begin
                        state_n  = HURT;
                        iframe_n = IF_LOAD;
                    end
                end else if (heal) begin
                    target_n = sat_add(target_hp, heal_amt, HP_FULL);
                end
            end
            HURT: begin
                if (heal)
                    target_n = sat_add(target_hp, heal_amt, HP_FULL);
                if (frame_tick) begin
                    iframe_n = iframe_cnt - 8'd1;
                    if (iframe_cnt == 8'd1)
                        state_n = ALIVE;
                end
            end
            DEAD: begin
                if (revive) begin
                    target_n = HP_FULL;
                    state_n  = ALIVE;
                end
            end
            default: state_n = ALIVE;
        endcase
    end

    // Displayed health: drain by 1 or fill by up to 2 per frame, never past target
    always_comb begin
        disp_gap = target_hp - disp_hp;
        disp_n   = disp_hp;
        if (frame_tick) begin
            if (disp_hp > target_hp)
                disp_n = disp_hp - 6'd1;
            else if (disp_hp < target_hp)
                disp_n = disp_hp + ((disp_gap >= 6'd2) ? 6'd2 : disp_gap);
        end
    end

    // State registers and registered outputs; flags are taken from the next
    // state so they change in the same cycle as the state itself
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ALIVE;
            target_hp  <= HP_FULL;
            disp_hp    <= HP_FULL;
            iframe_cnt <= '0;
            blood      <= {1'b0, HP_FULL} + OFS;
            is_dead    <= 1'b0;
            hurt_flash <= 1'b0;
        end else begin
            state      <= state_n;
            target_hp  <= target_n;
            disp_hp    <= disp_n;
            iframe_cnt <= iframe_n;
            blood      <= {1'b0, disp_hp} + OFS;
            is_dead    <= (state_n == DEAD);
            hurt_flash <= (state_n == HURT) & iframe_n[2];
        end
    end

endmodule

// File: tb/tb_blood_ctrl.sv
// Directed self-checking bench for blood_ctrl.
module tb_blood_ctrl;

    import blood_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       hit = 1'b0;
    logic [6:0] damage = '0;
    logic       heal = 1'b0;
    logic [6:0] heal_amt = '0;
    logic       revive = 1'b0;
    logic [6:0] blood;
    logic       is_dead;
    logic       hurt_flash;

    int checks = 0;
    int errors = 0;
    int exp_disp;
    int exp_tgt;

    blood_ctrl #(
        .HP_MAX     (61),
        .IFRAMES    (30),
        .BAR_OFFSET (2)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .hit        (hit),
        .damage     (damage),
        .heal       (heal),
        .heal_amt   (heal_amt),
        .revive     (revive),
        .blood      (blood),
        .is_dead    (is_dead),
        .hurt_flash (hurt_flash)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // reference animation step for displayed health
    function automatic int step(input int d, input int t);
        if (d > t) return d - 1;
        if (d < t) return d + (((t - d) >= 2) ? 2 : (t - d));
        return d;
    endfunction

    // one full frame strobe period; the resulting tick has reached blood on return
    task automatic tick_frame();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic pulse(input logic do_hit, input int dmg, input logic do_heal,
                         input int amt, input logic do_rev);
        @(negedge Clk);
        hit      = do_hit;
        damage   = 7'(dmg);
        heal     = do_heal;
        heal_amt = 7'(amt);
        revive   = do_rev;
        @(negedge Clk);
        hit    = 1'b0;
        heal   = 1'b0;
        revive = 1'b0;
    endtask

    initial begin
        // reset with the strobe already high
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_blood", 32'(blood), 63);
        chk("rst_dead", 32'(is_dead), 0);
        chk("rst_flash", 32'(hurt_flash), 0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("no_tick_after_rst", 32'(dut.u_tick.frame_tick), 0);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        exp_disp = 61;
        exp_tgt  = 61;

        for (int i = 0; i < 3; i++) begin
            tick_frame();
            chk("idle_blood", 32'(blood), 63);
            chk("idle_flash", 32'(hurt_flash), 0);
            chk("idle_dead", 32'(is_dead), 0);
        end

        // hit and heal together in ALIVE: hit wins
        pulse(1'b1, 5, 1'b1, 20, 1'b0);
        chk("hitheal_tgt", 32'(dut.target_hp), 56);
        chk("hitheal_state", 32'(dut.state), 32'(HURT));
        chk("hitheal_flash", 32'(hurt_flash), 1);
        // heal in HURT saturates at max
        pulse(1'b0, 0, 1'b1, 20, 1'b0);
        chk("hurtheal_tgt", 32'(dut.target_hp), 61);

        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        chk("rst2_state", 32'(dut.state), 32'(ALIVE));

        // damage 10, then a second hit while invulnerable
        pulse(1'b1, 10, 1'b0, 0, 1'b0);
        exp_tgt = 51;
        chk("hit10_tgt", 32'(dut.target_hp), 51);
        chk("hit10_state", 32'(dut.state), 32'(HURT));
        chk("hit10_dead", 32'(is_dead), 0);
        pulse(1'b1, 10, 1'b0, 0, 1'b0);
        chk("hurt_hit_ign", 32'(dut.target_hp), 51);
        for (int i = 1; i <= 30; i++) begin
            tick_frame();
            exp_disp = step(exp_disp, exp_tgt);
            chk("drain_blood", 32'(blood), 32'(exp_disp + 2));
            chk("iframe_state", 32'(dut.state), (i < 30) ? 32'(HURT) : 32'(ALIVE));
            chk("iframe_flash", 32'(hurt_flash), ((i < 30) && (((30 - i) & 4) != 0)) ? 1 : 0);
        end
        chk("drain_end", 32'(blood), 53);

        // fatal hit
        pulse(1'b1, 100, 1'b0, 0, 1'b0);
        exp_tgt = 0;
        chk("kill_dead", 32'(is_dead), 1);
        chk("kill_tgt", 32'(dut.target_hp), 0);
        pulse(1'b0, 0, 1'b1, 20, 1'b0);
        chk("dead_heal_ign", 32'(dut.target_hp), 0);
        pulse(1'b1, 5, 1'b0, 0, 1'b0);
        chk("dead_hit_state", 32'(dut.state), 32'(DEAD));
        for (int i = 0; i < 52; i++) begin
            tick_frame();
            exp_disp = step(exp_disp, exp_tgt);
            chk("death_blood", 32'(blood), 32'(exp_disp + 2));
        end
        chk("death_floor", 32'(blood), 2);
        chk("death_dead", 32'(is_dead), 1);

        // revive and refill
        pulse(1'b0, 0, 1'b0, 0, 1'b1);
        exp_tgt = 61;
        chk("rev_dead", 32'(is_dead), 0);
        chk("rev_state", 32'(dut.state), 32'(ALIVE));
        chk("rev_tgt", 32'(dut.target_hp), 61);
        for (int i = 0; i < 31; i++) begin
            tick_frame();
            exp_disp = step(exp_disp, exp_tgt);
            chk("fill_blood", 32'(blood), 32'(exp_disp + 2));
        end
        chk("fill_top", 32'(blood), 63);

        // reset in HURT mid-drain, with a fatal hit presented in the same cycle
        pulse(1'b1, 21, 1'b0, 0, 1'b0);
        exp_tgt = 40;
        for (int i = 0; i < 21; i++) begin
            tick_frame();
            exp_disp = step(exp_disp, exp_tgt);
        end
        chk("pre_rst_blood", 32'(blood), 42);
        chk("pre_rst_state", 32'(dut.state), 32'(HURT));
        @(negedge Clk);
        Reset  = 1'b1;
        hit    = 1'b1;
        damage = 7'd100;
        @(negedge Clk);
        Reset = 1'b0;
        hit   = 1'b0;
        chk("rst_hurt_blood", 32'(blood), 63);
        chk("rst_hurt_state", 32'(dut.state), 32'(ALIVE));
        chk("rst_hurt_flash", 32'(hurt_flash), 0);
        chk("rst_hurt_dead", 32'(is_dead), 0);
        chk("rst_hurt_tgt", 32'(dut.target_hp), 61);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
